// File: rtl/dem_sweep_ctrl.sv
// dem_sweep_ctrl: steps a square-wave output through eight rates, each period
// R times shorter than the one before, holding HOLD full periods per rate.
// One shared counter serves every rate. The outputs are registered, and each
// output register is loaded from the next-state values so that it lines up
// with the counter value of the same cycle.
// Optional feature: define SWEEP_LOOP_EN to make the sweep wrap back to its
// start index instead of finishing. The sweep then ends only on stop or reset.
module dem_sweep_ctrl #(
  parameter int unsigned M    = 500000000,
  parameter int unsigned R    = 10,
  parameter int unsigned N    = 30,
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  output logic       wave,
  output logic [2:0] idx,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [N-1:0] P0 = N'(M);
  localparam logic [N-1:0] P1 = N'(M / R);
  localparam logic [N-1:0] P2 = N'(M / (R ** 2));
  localparam logic [N-1:0] P3 = N'(M / (R ** 3));
  localparam logic [N-1:0] P4 = N'(M / (R ** 4));
  localparam logic [N-1:0] P5 = N'(M / (R ** 5));
  localparam logic [N-1:0] P6 = N'(M / (R ** 6));
  localparam logic [N-1:0] P7 = N'(M / (R ** 7));

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  // Period in clk cycles for rate index k
  function automatic logic [N-1:0] period_of(input logic [2:0] k);
    case (k)
      3'd0:    period_of = P0;
      3'd1:    period_of = P1;
      3'd2:    period_of = P2;
      3'd3:    period_of = P3;
      3'd4:    period_of = P4;
      3'd5:    period_of = P5;
      3'd6:    period_of = P6;
      default: period_of = P7;
    endcase
  endfunction

  logic [1:0]   state, state_n;
  logic [N-1:0] cnt, cnt_n;
  logic [7:0]   pcnt, pcnt_n;
  logic [2:0]   idx_n;
  logic         dir_q, dir_n;
  logic         wave_n, tick_n, busy_n, done_n;
  logic [N-1:0] per_cur, per_nxt;
  logic         at_last, at_final;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pcnt  <= '0;
      idx   <= '0;
      dir_q <= 1'b0;
      wave  <= 1'b0;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pcnt  <= pcnt_n;
      idx   <= idx_n;
      dir_q <= dir_n;
      wave  <= wave_n;
      tick  <= tick_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state, counter updates and next-cycle output values
  always_comb begin
    state_n  = state;
    cnt_n    = '0;
    pcnt_n   = pcnt;
    idx_n    = idx;
    dir_n    = dir_q;
    per_cur  = period_of(idx);
    at_last  = (cnt == per_cur - N'(1));
    at_final = dir_q ? (idx == 3'd0) : (idx == 3'd7);

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_RUN;
          pcnt_n  = '0;
          dir_n   = dir;
          idx_n   = {3{dir}};
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (!at_last) begin
          cnt_n = cnt + N'(1);
        end else if (pcnt != HOLD_LAST) begin
          pcnt_n = pcnt + 8'd1;
        end else if (!at_final) begin
          pcnt_n = '0;
          idx_n  = dir_q ? (idx - 3'd1) : (idx + 3'd1);
        end else begin
`ifdef SWEEP_LOOP_EN
          pcnt_n = '0;
          idx_n  = {3{dir_q}};
`else
          state_n = S_FIN;
`endif
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    per_nxt = period_of(idx_n);
    busy_n  = (state_n == S_RUN);
    done_n  = (state_n == S_FIN);
    wave_n  = busy_n && (cnt_n >= (per_nxt >> 1));
    tick_n  = busy_n && (cnt_n == per_nxt - N'(1));
  end

endmodule
